// File: rtl/led_bounce_ctrl.sv
// Bouncing single-LED pattern generator with run/pause/stop control,
// single stepping and a saturating adjustable step period.
module led_bounce_ctrl #(
   parameter int unsigned DEFAULT_PERIOD = 25_000_000,
   parameter int unsigned MIN_PERIOD     = 2_500_000,
   parameter int unsigned MAX_PERIOD     = 50_000_000,
   parameter int unsigned PERIOD_DELTA   = 2_500_000,
   parameter int unsigned PERIOD_W       = 26
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                pause,
   input  logic                stop,
   input  logic                single_step,
   input  logic                faster,
   input  logic                slower,
   output logic [7:0]          leds,
   output logic                step_tick,
   output logic                running,
   output logic [2:0]          position,
   output logic                direction,
   output logic [PERIOD_W-1:0] period
);

   localparam int unsigned POS_W = 3;
   localparam int unsigned LED_N = 8;

   localparam logic [PERIOD_W-1:0] DEF_P   = PERIOD_W'(DEFAULT_PERIOD);
   localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] MAX_P   = PERIOD_W'(MAX_PERIOD);
   localparam logic [PERIOD_W-1:0] DELTA_P = PERIOD_W'(PERIOD_DELTA);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2
   } state_e;

   state_e              state_q,   state_d;
   logic [PERIOD_W-1:0] cnt_q,     cnt_d;
   logic [PERIOD_W-1:0] period_q,  period_d;
   logic [POS_W-1:0]    pos_q,     pos_d;
   logic                dir_q,     dir_d;
   logic [LED_N-1:0]    leds_q,    leds_d;
   logic                tick_q,    tick_d;
   logic                running_q, running_d;

   logic                do_step;
   logic                go_home;
   logic [PERIOD_W-1:0] period_m1;

   assign period_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

   // Control FSM, counter, bounce stepping and period adjustment
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      do_step  = 1'b0;
      go_home  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (stop) begin
               go_home = 1'b1;
            end else if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else if (single_step && !pause) begin
               do_step = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               go_home = 1'b1;
            end else if (pause) begin
               state_d = S_PAUSED;
            end else if (cnt_q >= period_m1) begin
               cnt_d   = '0;
               do_step = 1'b1;
            end else begin
               cnt_d = cnt_q + PERIOD_W'(1);
            end
         end
         S_PAUSED: begin
            if (stop) begin
               go_home = 1'b1;
            end else if (pause) begin
               state_d = S_PAUSED;
            end else if (start) begin
               state_d = S_RUN;
            end else if (single_step) begin
               do_step = 1'b1;
            end
         end
         default: begin
            go_home = 1'b1;
         end
      endcase

      if (do_step) begin
         if (!dir_q) begin
            if (pos_q == POS_W'(7)) begin
               dir_d = 1'b1;
               pos_d = POS_W'(6);
            end else begin
               pos_d = pos_q + POS_W'(1);
            end
         end else begin
            if (pos_q == '0) begin
               dir_d = 1'b0;
               pos_d = POS_W'(1);
            end else begin
               pos_d = pos_q - POS_W'(1);
            end
         end
      end

      if (go_home) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         pos_d   = '0;
         dir_d   = 1'b0;
      end

      // Saturating period update; subtractions are guarded so they never wrap
      case ({faster, slower})
         2'b10: begin
            if ((period_q <= MIN_P) || ((period_q - MIN_P) < DELTA_P)) begin
               period_d = MIN_P;
            end else begin
               period_d = period_q - DELTA_P;
            end
         end
         2'b01: begin
            if ((period_q >= MAX_P) || ((MAX_P - period_q) < DELTA_P)) begin
               period_d = MAX_P;
            end else begin
               period_d = period_q + DELTA_P;
            end
         end
         default: period_d = period_q;
      endcase

      leds_d    = LED_N'(1) << pos_d;
      tick_d    = do_step;
      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         period_q  <= DEF_P;
         pos_q     <= '0;
         dir_q     <= 1'b0;
         leds_q    <= LED_N'(1);
         tick_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         leds_q    <= leds_d;
         tick_q    <= tick_d;
         running_q <= running_d;
      end
   end

   assign leds      = leds_q;
   assign step_tick = tick_q;
   assign running   = running_q;
   assign position  = pos_q;
   assign direction = dir_q;
   assign period    = period_q;

endmodule

// File: tb/tb_led_bounce_ctrl.sv
// Scoreboard bench for led_bounce_ctrl: expected step outputs are queued as
// stimulus is applied and checked whenever step_tick is seen.
module tb_led_bounce_ctrl;

   localparam int unsigned PW = 8;

   localparam logic [6:0] RST = 7'h40;
   localparam logic [6:0] STA = 7'h20;
   localparam logic [6:0] PAU = 7'h10;
   localparam logic [6:0] STP = 7'h08;
   localparam logic [6:0] SST = 7'h04;
   localparam logic [6:0] FST = 7'h02;
   localparam logic [6:0] SLW = 7'h01;

   logic          clk = 1'b0;
   logic          reset, start, pause, stop, single_step, faster, slower;
   logic [7:0]    leds;
   logic          step_tick, running, direction;
   logic [2:0]    position;
   logic [PW-1:0] period;

   int n_chk     = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int tick_cnt  = 0;
   int last_tick = -1;
   bit gap_en    = 1'b0;

   logic [11:0] sb_q[$];
   logic [11:0] sb_e;
   logic [2:0]  m_pos;
   logic        m_dir;

   led_bounce_ctrl #(
      .DEFAULT_PERIOD(4),
      .MIN_PERIOD    (2),
      .MAX_PERIOD    (8),
      .PERIOD_DELTA  (2),
      .PERIOD_W      (PW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .single_step(single_step),
      .faster     (faster),
      .slower     (slower),
      .leds       (leds),
      .step_tick  (step_tick),
      .running    (running),
      .position   (position),
      .direction  (direction),
      .period     (period)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_in(input logic [6:0] v);
      {reset, start, pause, stop, single_step, faster, slower} = v;
   endtask

   task automatic pulse(input logic [6:0] v);
      set_in(v);
      @(negedge clk);
      set_in(7'h00);
   endtask

   // Advance the reference bounce model and queue the outputs it predicts
   task automatic push_step();
      logic [7:0] l;
      if (!m_dir) begin
         if (m_pos == 3'd7) begin m_dir = 1'b1; m_pos = 3'd6; end
         else m_pos = m_pos + 3'd1;
      end else begin
         if (m_pos == 3'd0) begin m_dir = 1'b0; m_pos = 3'd1; end
         else m_pos = m_pos - 3'd1;
      end
      l = 8'b1 << m_pos;
      sb_q.push_back({m_dir, m_pos, l});
   endtask

   task automatic wait_sb(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("sb_drain", 32'(sb_q.size()), 0);
      sb_q.delete();
   endtask

   always @(negedge clk) begin
      if (step_tick === 1'b1) begin
         tick_cnt++;
         if (sb_q.size() == 0) begin
            check("spurious_tick", 32'(step_tick), 0);
         end else begin
            sb_e = sb_q.pop_front();
            check("step_out", {20'd0, direction, position, leds}, {20'd0, sb_e});
         end
         if (gap_en && last_tick >= 0) check("tick_gap", 32'(cyc - last_tick), 4);
         last_tick = cyc;
      end
   end

   initial begin
      int s;
      int snap;
      int exp_slow[3] = '{6, 8, 8};
      int exp_fast[4] = '{6, 4, 2, 2};

      set_in(RST);
      m_pos = 3'd0;
      m_dir = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_leds", 32'(leds), 32'h01);
      check("rst_pos", 32'(position), 0);
      check("rst_dir", 32'(direction), 0);
      check("rst_period", 32'(period), 4);
      check("rst_tick", 32'(step_tick), 0);
      check("rst_running", 32'(running), 0);
      set_in(7'h00);
      @(negedge clk);

      // Free run through a full bounce with 4-cycle spacing
      gap_en = 1'b1;
      for (int i = 0; i < 16; i++) push_step();
      pulse(STA);
      wait_sb(100);
      gap_en = 1'b0;
      check("run_running", 32'(running), 1);
      pulse(STP);
      m_pos = 3'd0;
      m_dir = 1'b0;
      check("stop_leds", 32'(leds), 32'h01);
      check("stop_running", 32'(running), 0);

      // Pause two cycles into a period, then resume from the held count
      pulse(STA);
      repeat (2) @(negedge clk);
      snap = tick_cnt;
      set_in(PAU);
      repeat (5) @(negedge clk);
      check("pause_no_tick", 32'(tick_cnt - snap), 0);
      check("pause_running", 32'(running), 0);
      push_step();
      set_in(STA);
      s = cyc + 1;
      @(negedge clk);
      set_in(7'h00);
      wait_sb(10);
      check("resume_latency", 32'(last_tick), 32'(s + 2));

      // Period saturation in IDLE
      pulse(STP);
      m_pos = 3'd0;
      m_dir = 1'b0;
      foreach (exp_slow[i]) begin
         pulse(SLW);
         check("period_slower", 32'(period), 32'(exp_slow[i]));
      end
      foreach (exp_fast[i]) begin
         pulse(FST);
         check("period_faster", 32'(period), 32'(exp_fast[i]));
      end
      pulse(FST | SLW);
      check("period_both_min", 32'(period), 2);
      pulse(SLW);
      pulse(FST | SLW);
      check("period_both_mid", 32'(period), 4);

      // Single-step to position 3 heading down, then step once while paused
      for (int i = 0; i < 11; i++) begin
         push_step();
         pulse(SST);
         wait_sb(4);
      end
      check("sstep_pos", 32'(position), 3);
      check("sstep_dir", 32'(direction), 1);
      pulse(STA);
      pulse(PAU);
      check("paused_running", 32'(running), 0);
      push_step();
      pulse(SST);
      wait_sb(4);
      check("paused_sstep_pos", 32'(position), 2);
      pulse(STA);
      s = cyc;
      pulse(SST);
      check("run_sstep_no_tick", 32'(step_tick), 0);
      push_step();
      wait_sb(10);
      check("run_step_latency", 32'(last_tick), 32'(s + 4));

      // stop beats pause and start
      pulse(STP | PAU | STA);
      m_pos = 3'd0;
      m_dir = 1'b0;
      check("prio_running", 32'(running), 0);
      check("prio_leds", 32'(leds), 32'h01);
      check("prio_pos", 32'(position), 0);
      pulse(SLW);
      check("pre_rst_period", 32'(period), 6);

      // Reset mid-run overrides commands sampled with it
      pulse(STA);
      repeat (2) @(negedge clk);
      set_in(RST | STA | FST);
      @(negedge clk);
      check("mrst_leds", 32'(leds), 32'h01);
      check("mrst_pos", 32'(position), 0);
      check("mrst_dir", 32'(direction), 0);
      check("mrst_period", 32'(period), 4);
      check("mrst_tick", 32'(step_tick), 0);
      check("mrst_running", 32'(running), 0);
      set_in(7'h00);
      repeat (8) @(negedge clk);
      check("sb_final", 32'(sb_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
